adc_acq_sequencer: RTL and testbench
====================================

ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

Interface
REQ-001 Parameter PERIOD_DEF, default 50, conversion period in clocks used when cfg_period is 0 (50 clocks at 100 MHz gives 2 MSPS).
REQ-002 Parameter PERIOD_MIN, default 20, lower clamp for the latched period.
REQ-003 Parameter NS_W, default 24, width of the sample counter.
REQ-004 PLL_clk_100MHz  in  1  sole clock; every flop is posedge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 cmd_arm  in  1  single-cycle pulse; arm acquisition.
REQ-007 cmd_trig  in  1  single-cycle pulse; start acquisition when armed.
REQ-008 cmd_stop  in  1  single-cycle pulse; stop acquisition at the frame boundary.
REQ-009 cfg_period  in  8  conversion period in clocks; 0 selects PERIOD_DEF.
REQ-010 cfg_nsamples  in  NS_W  number of samples to take; 0 means continuous.
REQ-011 adc_start_conv_n  out  1  ADC convert strobe, active-low.
REQ-012 adc_word_sync_n  out  1  ADC word sync, active-low.
REQ-013 sample_tick  out  1  one-cycle pulse at the end of each conversion frame.
REQ-014 sample_count  out  NS_W  number of frames completed in the current run.
REQ-015 state  out  2  0=IDLE, 1=ARMED, 2=ACQ, 3=DONE.
REQ-016 done_pulse  out  1  one-cycle pulse when the sequencer enters DONE.

Function
REQ-017 The FSM SHALL implement IDLE->ARMED on cmd_arm, ARMED->ACQ on cmd_trig, ACQ->DONE at the end of the last frame or at the first frame end after a stop, and DONE->IDLE after exactly 1 cycle.
REQ-018 On cmd_arm in IDLE, the block SHALL latch P = max(cfg_period or PERIOD_DEF, PERIOD_MIN) and N = cfg_nsamples, and SHALL clear sample_count.
REQ-019 Changes to cfg_* outside IDLE SHALL have no effect until the next arm.
REQ-020 The phase counter SHALL be 0 in the first ACQ cycle (the cycle after cmd_trig is sampled) and SHALL count 0..P-1, wrapping to 0.
REQ-021 adc_word_sync_n SHALL be low exactly while phase is in [P-17, P-13] (5 cycles) and high otherwise.
REQ-022 adc_start_conv_n SHALL be low exactly while phase is in [P-7, P-1] (7 cycles) and high otherwise.
REQ-023 Both ADC outputs SHALL be registered and high in every state other than ACQ.
REQ-024 At phase P-1, sample_tick SHALL pulse and sample_count SHALL increment in the same cycle; sample_count saturates at its all-ones value.
REQ-025 If N != 0 and the increment makes sample_count equal to N, the next state SHALL be DONE.
REQ-026 If N = 0, ACQ SHALL continue until a stop.
REQ-027 cmd_stop in ACQ SHALL set a stop-pending flag; the run SHALL end at the next phase P-1 (the current frame completes), and the flag SHALL clear on entry to DONE.
REQ-028 cmd_stop in ARMED SHALL return the FSM to IDLE with no done_pulse.
REQ-029 cmd_stop asserted together with cmd_arm or cmd_trig in the same cycle SHALL win.
REQ-030 cmd_trig in IDLE, ACQ or DONE SHALL be ignored, and cmd_arm outside IDLE SHALL be ignored.
REQ-031 done_pulse SHALL assert for the single cycle the FSM is in DONE.
REQ-032 sample_count SHALL hold its value through DONE and IDLE until the next arm.

Reset
REQ-033 Assertion of rst_n SHALL immediately force: state IDLE, phase 0, stop flag 0, sample_count 0, adc_start_conv_n = 1, adc_word_sync_n = 1, sample_tick = 0, done_pulse = 0, P = PERIOD_DEF, N = 0.
REQ-034 Reset mid-acquisition SHALL abort the current frame with no partial strobe after release.
REQ-035 Release of rst_n SHALL be synchronised to PLL_clk_100MHz by a 2-flop reset synchroniser inside the block.

Structure
REQ-036 A shared package acq_pkg SHALL hold the state encoding constants (IDLE..DONE), PERIOD_DEF, PERIOD_MIN, and the strobe window offsets 17, 13, 7 and 1.
REQ-037 The phase counter plus window decode SHALL be one sub-module, acq_phase_gen, with inputs enable and P, and outputs phase, word_sync_n, start_conv_n and frame_end.

Verification
REQ-038 Scenario: cfg_period=0, nsamples=3, arm, trig -> 3 frames of 50 cycles; start_conv_n low at phases 43..49 and word_sync_n low at phases 33..37; 3 sample_ticks; done_pulse 150 cycles after the first ACQ cycle; then IDLE.
REQ-039 Scenario: cfg_period=10 -> P clamps to 20; start_conv_n low at phases 13..19 and word_sync_n low at phases 3..7.
REQ-040 Scenario: nsamples=0, cmd_stop at phase 5 of frame 4 -> frame 4 completes, sample_count=4, done_pulse, IDLE.
REQ-041 Scenario: arm, then cmd_trig and cmd_stop in the same cycle -> IDLE, no strobes, no done_pulse.
REQ-042 Scenario: rst_n low at phase 45 -> both ADC outputs high within the same cycle; after release, state=IDLE and sample_count=0.
REQ-043 Scenario: cfg_period changed to 80 during ACQ -> the current run keeps P=50; the next arm uses 80.

Source files
------------

// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state encoding, period limits and strobe window offsets
package acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACQ   = 2'd2,
    ST_DONE  = 2'd3
  } acq_state_t;

  localparam int ACQ_PERIOD_DEF = 50;
  localparam int ACQ_PERIOD_MIN = 20;

  // Offsets are subtracted from P: word sync low at [P-17, P-13], convert low at [P-7, P-1].
  localparam logic [7:0] WS_LO_OFS = 8'd17;
  localparam logic [7:0] WS_HI_OFS = 8'd13;
  localparam logic [7:0] SC_LO_OFS = 8'd7;
  localparam logic [7:0] SC_HI_OFS = 8'd1;

  function automatic logic in_window(input logic [7:0] phase, input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (phase >= lo) && (phase <= hi);
  endfunction

endpackage

// File: rtl/acq_phase_gen.sv
// rtl/acq_phase_gen.sv - conversion phase counter with registered ADC strobe decode
module acq_phase_gen
  import acq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [7:0] i_period,
  output logic [7:0] o_phase,
  output logic       o_word_sync_n,
  output logic       o_start_conv_n,
  output logic       o_frame_end
);

  logic       r_run;
  logic [7:0] r_phase;
  logic       r_ws_n;
  logic       r_sc_n;
  logic       w_last;
  logic [7:0] w_phase_nxt;

  assign w_last = r_run && (r_phase == i_period - 8'd1);

  // i_enable means "running next cycle", so strobes are decoded from the next phase.
  always_comb begin
    w_phase_nxt = 8'd0;
    if (i_enable && r_run && !w_last) begin
      w_phase_nxt = r_phase + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      r_phase <= 8'd0;
      r_ws_n  <= 1'b1;
      r_sc_n  <= 1'b1;
    end else begin
      r_run   <= i_enable;
      r_phase <= w_phase_nxt;
      r_ws_n  <= !(i_enable && in_window(w_phase_nxt, i_period - WS_LO_OFS, i_period - WS_HI_OFS));
      r_sc_n  <= !(i_enable && in_window(w_phase_nxt, i_period - SC_LO_OFS, i_period - SC_HI_OFS));
    end
  end

  assign o_phase        = r_phase;
  assign o_word_sync_n  = r_ws_n;
  assign o_start_conv_n = r_sc_n;
  assign o_frame_end    = w_last;

endmodule

// File: rtl/adc_acq_sequencer.sv
// rtl/adc_acq_sequencer.sv - arm/trigger/stop ADC acquisition sequencer
module adc_acq_sequencer
  import acq_pkg::*;
#(
  parameter int PERIOD_DEF = ACQ_PERIOD_DEF,
  parameter int PERIOD_MIN = ACQ_PERIOD_MIN,
  parameter int NS_W       = 24
) (
  input  logic            PLL_clk_100MHz,
  input  logic            rst_n,
  input  logic            cmd_arm,
  input  logic            cmd_trig,
  input  logic            cmd_stop,
  input  logic [7:0]      cfg_period,
  input  logic [NS_W-1:0] cfg_nsamples,
  output logic            adc_start_conv_n,
  output logic            adc_word_sync_n,
  output logic            sample_tick,
  output logic [NS_W-1:0] sample_count,
  output logic [1:0]      state,
  output logic            done_pulse
);

  localparam logic [7:0] LP_DEF = 8'(PERIOD_DEF);
  localparam logic [7:0] LP_MIN = 8'(PERIOD_MIN);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  acq_state_t      r_state, w_state_nxt;
  logic            r_stop, w_stop_nxt;
  logic [NS_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]      r_p, w_p_nxt, w_p_cfg, w_p_sel;
  logic [NS_W-1:0] r_n, w_n_nxt;
  logic [7:0]      w_unused_phase;
  logic            w_frame_end;

  // Assertion is immediate; release reaches the core two clocks later.
  always_ff @(posedge PLL_clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_p_sel   = (cfg_period == 8'd0) ? LP_DEF : cfg_period;
  assign w_p_cfg   = (w_p_sel < LP_MIN) ? LP_MIN : w_p_sel;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + NS_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_stop_nxt  = r_stop;
    w_cnt_nxt   = r_cnt;
    w_p_nxt     = r_p;
    w_n_nxt     = r_n;
    case (r_state)
      ST_IDLE: begin
        if (cmd_arm && !cmd_stop) begin
          w_state_nxt = ST_ARMED;
          w_p_nxt     = w_p_cfg;
          w_n_nxt     = cfg_nsamples;
          w_cnt_nxt   = '0;
        end
      end
      ST_ARMED: begin
        if (cmd_stop)      w_state_nxt = ST_IDLE;
        else if (cmd_trig) w_state_nxt = ST_ACQ;
      end
      ST_ACQ: begin
        if (cmd_stop) w_stop_nxt = 1'b1;
        if (w_frame_end) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_stop || cmd_stop || ((r_n != '0) && (w_cnt_inc == r_n))) begin
            w_state_nxt = ST_DONE;
            w_stop_nxt  = 1'b0;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PLL_clk_100MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_stop  <= 1'b0;
      r_cnt   <= '0;
      r_p     <= LP_DEF;
      r_n     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stop  <= w_stop_nxt;
      r_cnt   <= w_cnt_nxt;
      r_p     <= w_p_nxt;
      r_n     <= w_n_nxt;
    end
  end

  acq_phase_gen u_phase_gen (
    .i_clk          (PLL_clk_100MHz),
    .i_rst_n        (w_rst_n),
    .i_enable       (w_state_nxt == ST_ACQ),
    .i_period       (r_p),
    .o_phase        (w_unused_phase),
    .o_word_sync_n  (adc_word_sync_n),
    .o_start_conv_n (adc_start_conv_n),
    .o_frame_end    (w_frame_end)
  );

  assign sample_tick  = w_frame_end;
  assign sample_count = r_cnt;
  assign state        = r_state;
  assign done_pulse   = (r_state == ST_DONE);

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb/tb_adc_acq_sequencer.sv - directed scoreboard bench for adc_acq_sequencer
module tb_adc_acq_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_arm, cmd_trig, cmd_stop;
  logic [7:0]  cfg_period;
  logic [23:0] cfg_nsamples;
  logic        adc_start_conv_n, adc_word_sync_n, sample_tick, done_pulse;
  logic [23:0] sample_count;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  adc_acq_sequencer dut (
    .PLL_clk_100MHz   (clk),
    .rst_n            (rst_n),
    .cmd_arm          (cmd_arm),
    .cmd_trig         (cmd_trig),
    .cmd_stop         (cmd_stop),
    .cfg_period       (cfg_period),
    .cfg_nsamples     (cfg_nsamples),
    .adc_start_conv_n (adc_start_conv_n),
    .adc_word_sync_n  (adc_word_sync_n),
    .sample_tick      (sample_tick),
    .sample_count     (sample_count),
    .state            (state),
    .done_pulse       (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_counts(input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back(i);
  endtask

  // Starts at the first ACQ cycle; expected windows are given as absolute phases.
  task automatic run_acq(input int p, input int ws_lo, input int sc_lo, input int ncyc,
                         input int stop_k, input bit expect_done, input int final_cnt);
    for (int k = 0; k < ncyc; k++) begin
      int ph = k % p;
      logic t;
      chk("acq_state", state, 2);
      chk("word_sync_n", adc_word_sync_n, !(ph >= ws_lo && ph <= ws_lo + 4));
      chk("start_conv_n", adc_start_conv_n, !(ph >= sc_lo && ph <= sc_lo + 6));
      chk("tick_phase", sample_tick, ph == p - 1);
      chk("done_in_acq", done_pulse, 0);
      t = sample_tick;
      if (k == stop_k) cmd_stop = 1'b1;
      step(1);
      cmd_stop = 1'b0;
      if (t) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("sample_count", sample_count, exp_q.pop_front());
      end
    end
    if (expect_done) begin
      chk("done_state", state, 3);
      chk("done_pulse", done_pulse, 1);
      chk("done_sc_n", adc_start_conv_n, 1);
      chk("done_ws_n", adc_word_sync_n, 1);
      chk("done_tick", sample_tick, 0);
      step(1);
      chk("idle_state", state, 0);
      chk("idle_done", done_pulse, 0);
      chk("idle_count_hold", sample_count, final_cnt);
      step(5);
      chk("idle_count_hold2", sample_count, final_cnt);
    end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_arm();
    cmd_arm = 1'b1; step(1); cmd_arm = 1'b0;
  endtask

  task automatic pulse_trig();
    cmd_trig = 1'b1; step(1); cmd_trig = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_arm = 1'b0; cmd_trig = 1'b0; cmd_stop = 1'b0;
    cfg_period = 8'd0; cfg_nsamples = 24'd0;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_sc_n", adc_start_conv_n, 1);
    chk("rst_ws_n", adc_word_sync_n, 1);
    chk("rst_tick", sample_tick, 0);
    chk("rst_done", done_pulse, 0);
    rst_n = 1'b1;
    step(3);

    pulse_trig();
    chk("trig_in_idle", state, 0);
    cmd_stop = 1'b1; pulse_arm(); cmd_stop = 1'b0;
    chk("arm_stop_idle", state, 0);
    pulse_arm();
    chk("armed", state, 1);
    cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
    chk("stop_armed_state", state, 0);
    chk("stop_armed_done", done_pulse, 0);

    // Default period, three frames.
    cfg_period = 8'd0; cfg_nsamples = 24'd3;
    pulse_arm();
    push_counts(3);
    pulse_trig();
    run_acq(50, 33, 43, 150, -1, 1, 3);

    // Period clamps to 20; a second arm while ARMED is ignored.
    cfg_period = 8'd10; cfg_nsamples = 24'd2;
    pulse_arm();
    cfg_period = 8'd0; cfg_nsamples = 24'd5;
    pulse_arm();
    chk("rearm_ignored", state, 1);
    push_counts(2);
    pulse_trig();
    run_acq(20, 3, 13, 40, -1, 1, 2);

    // Continuous, stop at phase 5 of frame 4, period change mid-run.
    cfg_period = 8'd0; cfg_nsamples = 24'd0;
    pulse_arm();
    push_counts(4);
    pulse_trig();
    cfg_period = 8'd80;
    run_acq(50, 33, 43, 200, 155, 1, 4);

    cfg_nsamples = 24'd1;
    pulse_arm();
    push_counts(1);
    pulse_trig();
    run_acq(80, 63, 73, 80, -1, 1, 1);

    // Trigger and stop together: stop wins.
    cfg_period = 8'd0; cfg_nsamples = 24'd2;
    pulse_arm();
    chk("arm_clears_count", sample_count, 0);
    cmd_trig = 1'b1; cmd_stop = 1'b1; step(1); cmd_trig = 1'b0; cmd_stop = 1'b0;
    chk("trig_stop_state", state, 0);
    for (int i = 0; i < 60; i++) begin
      chk("ts_state", state, 0);
      chk("ts_sc_n", adc_start_conv_n, 1);
      chk("ts_ws_n", adc_word_sync_n, 1);
      chk("ts_tick", sample_tick, 0);
      chk("ts_done", done_pulse, 0);
      step(1);
    end

    // Reset at phase 45 of frame 2.
    cfg_nsamples = 24'd0;
    pulse_arm();
    push_counts(1);
    pulse_trig();
    run_acq(50, 33, 43, 95, -1, 0, 0);
    chk("pre_rst_sc_n", adc_start_conv_n, 0);
    rst_n = 1'b0;
    #1;
    chk("async_sc_n", adc_start_conv_n, 1);
    chk("async_ws_n", adc_word_sync_n, 1);
    chk("async_state", state, 0);
    chk("async_count", sample_count, 0);
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      chk("post_rst_state", state, 0);
      chk("post_rst_count", sample_count, 0);
      chk("post_rst_sc_n", adc_start_conv_n, 1);
      chk("post_rst_ws_n", adc_word_sync_n, 1);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
